// File: rtl/cache_wb_ctrl.sv
// -----------------------------------------------------------------------------
// cache_wb_ctrl
//   Direct-mapped, write-back, write-allocate data cache controller. It has
//   4 lines of 128-bit blocks (4 x 32-bit words) and sits between the CPU
//   load/store path and a combinational 1 KiB block memory. Each memory block
//   transfer (write-back or refill) is held for MEM_LAT cycles.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cpu_req           request valid, held stable until cpu_ready
//   cpu_we            1 = store word, 0 = load word
//   cpu_addr[9:0]     byte address: [9:6] tag, [5:4] index, [3:2] word
//   cpu_wdata[31:0]   store data
//   cpu_rdata[31:0]   load data, valid while cpu_ready = 1
//   cpu_ready         one-cycle completion pulse
//   cpu_hit           with cpu_ready: request needed no memory transfer
//   mem_addr[9:0]     block address {tag, index, 4'b0000}
//   mem_wt[127:0]     write block, word0 at [127:96]
//   mem_write         level write enable to memory
//   mem_rd[127:0]     read block from memory, same packing as mem_wt
// -----------------------------------------------------------------------------
module cache_wb_ctrl #(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [9:0]   cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         cpu_hit,
    output logic [9:0]   mem_addr,
    output logic [127:0] mem_wt,
    output logic         mem_write,
    input  logic [127:0] mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_cnt, w_cnt_nxt;

    // Latched request
    logic           r_req_we;
    logic [9:2]     r_req_addr;
    logic [31:0]    r_req_wdata;
    logic           r_nomem, w_nomem_nxt;

    // Line storage
    logic [3:0]     r_valid;
    logic [3:0]     r_dirty;
    logic [3:0]     r_tag  [4];
    logic [127:0]   r_data [4];

    // Registered outputs and their next values
    logic [31:0]    r_cpu_rdata, w_cpu_rdata_nxt;
    logic           r_cpu_ready, w_cpu_ready_nxt;
    logic           r_cpu_hit,   w_cpu_hit_nxt;
    logic [9:0]     r_mem_addr,  w_mem_addr_nxt;
    logic [127:0]   r_mem_wt,    w_mem_wt_nxt;
    logic           r_mem_write, w_mem_write_nxt;

    logic           w_latch_req;
    logic           w_line_fill;
    logic           w_line_store;

    logic [1:0]     w_idx;
    logic [3:0]     w_tag;
    logic [6:0]     w_lsb;
    logic [127:0]   w_line;
    logic           w_hit;
    logic [31:0]    w_word_rd;

    // Byte-offset bits are don't-care for word accesses.
    logic           w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^cpu_addr[1:0];

    assign w_idx     = r_req_addr[5:4];
    assign w_tag     = r_req_addr[9:6];
    // Word 0 sits in the top 32 bits, so the bit offset is (3 - word) * 32.
    assign w_lsb     = {~r_req_addr[3:2], 5'b00000};
    assign w_line    = r_data[w_idx];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word_rd = w_line[w_lsb +: 32];

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_nomem_nxt     = r_nomem;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_cpu_ready_nxt = 1'b0;
        w_cpu_hit_nxt   = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wt_nxt    = r_mem_wt;
        w_mem_write_nxt = 1'b0;
        w_latch_req     = 1'b0;
        w_line_fill     = 1'b0;
        w_line_store    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_latch_req = 1'b1;
                    w_nomem_nxt = 1'b1;
                    w_state_nxt = S_COMPARE;
                end
            end

            S_COMPARE: begin
                if (w_hit) begin
                    if (r_req_we) begin
                        w_line_store = 1'b1;
                    end else begin
                        w_cpu_rdata_nxt = w_word_rd;
                    end
                    w_state_nxt = S_RESP;
                end else begin
                    w_nomem_nxt = 1'b0;
                    w_cnt_nxt   = LAT_LOAD;
                    if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        w_mem_addr_nxt  = {r_tag[w_idx], w_idx, 4'b0000};
                        w_mem_wt_nxt    = w_line;
                        w_mem_write_nxt = 1'b1;
                        w_state_nxt     = S_WRITEBACK;
                    end else begin
                        w_mem_addr_nxt  = {w_tag, w_idx, 4'b0000};
                        w_state_nxt     = S_ALLOCATE;
                    end
                end
            end

            S_WRITEBACK: begin
                if (r_cnt == 4'd0) begin
                    // Write enable drops on the same edge the refill address appears.
                    w_cnt_nxt      = LAT_LOAD;
                    w_mem_addr_nxt = {w_tag, w_idx, 4'b0000};
                    w_state_nxt    = S_ALLOCATE;
                end else begin
                    w_cnt_nxt       = r_cnt - 4'd1;
                    w_mem_write_nxt = 1'b1;
                end
            end

            S_ALLOCATE: begin
                if (r_cnt == 4'd0) begin
                    w_line_fill = 1'b1;
                    w_state_nxt = S_COMPARE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            S_RESP: begin
                w_cpu_ready_nxt = 1'b1;
                w_cpu_hit_nxt   = r_nomem;
                w_state_nxt     = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_nomem     <= 1'b0;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_tag       <= '{default: '0};
            r_cpu_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_hit   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wt    <= '0;
            r_mem_write <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_nomem     <= w_nomem_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_cpu_ready <= w_cpu_ready_nxt;
            r_cpu_hit   <= w_cpu_hit_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wt    <= w_mem_wt_nxt;
            r_mem_write <= w_mem_write_nxt;
            if (w_latch_req) begin
                r_req_we    <= cpu_we;
                r_req_addr  <= cpu_addr[9:2];
                r_req_wdata <= cpu_wdata;
            end
            if (w_line_fill) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
                r_tag[w_idx]   <= w_tag;
            end else if (w_line_store) begin
                r_dirty[w_idx] <= 1'b1;
            end
        end
    end

    // NOTE: the data array has no reset; a line's contents are never used
    // until a refill has set its valid bit, and valid bits are reset above.
    always_ff @(posedge clk) begin
        if (w_line_fill) begin
            r_data[w_idx] <= mem_rd;
        end else if (w_line_store) begin
            r_data[w_idx][w_lsb +: 32] <= r_req_wdata;
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ready = r_cpu_ready;
    assign cpu_hit   = r_cpu_hit;
    assign mem_addr  = r_mem_addr;
    assign mem_wt    = r_mem_wt;
    assign mem_write = r_mem_write;

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_wb_ctrl
//   Self-checking bench for cache_wb_ctrl. A behavioural block memory answers
//   the memory port; a word-level cache/memory model predicts hit/miss,
//   write-backs, load data and latency for each request.
// -----------------------------------------------------------------------------
module tb_cache_wb_ctrl;

    localparam int L = 4;

    logic         clk;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_hit;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wt;
    logic         mem_write;
    logic [127:0] mem_rd;

    cache_wb_ctrl #(.MEM_LAT(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_hit   (cpu_hit),
        .mem_addr  (mem_addr),
        .mem_wt    (mem_wt),
        .mem_write (mem_write),
        .mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural block memory ----------------
    logic [31:0] init_img [256];
    logic [31:0] phys_mem [256];
    logic        load_mem;
    logic [7:0]  rd_base;

    assign rd_base = {mem_addr[9:4], 2'b00};
    assign mem_rd  = {phys_mem[rd_base], phys_mem[rd_base + 8'd1],
                      phys_mem[rd_base + 8'd2], phys_mem[rd_base + 8'd3]};

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) phys_mem[i] <= init_img[i];
        end else if (mem_write) begin
            for (int i = 0; i < 4; i++)
                phys_mem[rd_base + 8'(i)] <= mem_wt[127 - 32*i -: 32];
        end
    end

    // ---------------- memory-port monitor ----------------
    int           wr_cycles_total   = 0;
    int           wr_rises_total    = 0;
    int           wr_unstable_total = 0;
    bit           prev_wr = 1'b0;
    logic [9:0]   last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;

    always @(negedge clk) begin
        if (mem_write) begin
            wr_cycles_total <= wr_cycles_total + 1;
            if (!prev_wr)
                wr_rises_total <= wr_rises_total + 1;
            else if (mem_addr !== last_wr_addr || mem_wt !== last_wr_data)
                wr_unstable_total <= wr_unstable_total + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wt;
        end
        prev_wr <= mem_write;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem  [256];
    logic        rc_valid [4];
    logic        rc_dirty [4];
    logic [3:0]  rc_tag   [4];
    logic [31:0] rc_words [4][4];
    logic [9:0]  ref_last_addr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            rc_valid[i] = 1'b0;
            rc_dirty[i] = 1'b0;
            rc_tag[i]   = 4'h0;
        end
        ref_last_addr = '0;
    endtask

    task automatic do_req(input logic we, input logic [9:0] addr,
                          input logic [31:0] wdata, input string tag);
        logic [1:0]   idx;
        logic [3:0]   t;
        logic [1:0]   w;
        logic [7:0]   base;
        logic         exp_hit;
        logic         exp_wb;
        logic [9:0]   exp_wb_addr;
        logic [127:0] exp_wb_data;
        logic [31:0]  exp_rdata;
        int           exp_n, n, wc0, wr0, wu0;
        logic         got;

        idx = addr[5:4];
        t   = addr[9:6];
        w   = addr[3:2];
        exp_hit     = rc_valid[idx] && (rc_tag[idx] == t);
        exp_wb      = !exp_hit && rc_valid[idx] && rc_dirty[idx];
        exp_wb_addr = {rc_tag[idx], idx, 4'b0000};
        exp_wb_data = {rc_words[idx][0], rc_words[idx][1], rc_words[idx][2], rc_words[idx][3]};
        exp_rdata   = '0;
        if (exp_wb) begin
            base = {rc_tag[idx], idx, 2'b00};
            for (int k = 0; k < 4; k++) ref_mem[base + 8'(k)] = rc_words[idx][k];
        end
        if (!exp_hit) begin
            base = {t, idx, 2'b00};
            for (int k = 0; k < 4; k++) rc_words[idx][k] = ref_mem[base + 8'(k)];
            rc_valid[idx] = 1'b1;
            rc_dirty[idx] = 1'b0;
            rc_tag[idx]   = t;
            ref_last_addr = {t, idx, 4'b0000};
        end
        if (we) begin
            rc_words[idx][w] = wdata;
            rc_dirty[idx]    = 1'b1;
        end else begin
            exp_rdata = rc_words[idx][w];
        end
        exp_n = exp_hit ? 2 : (exp_wb ? 3 + 2*L : 3 + L);

        wc0 = wr_cycles_total;
        wr0 = wr_rises_total;
        wu0 = wr_unstable_total;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;

        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk);
            #1;
            if (cpu_ready) got = 1'b1;
            else n++;
        end
        cpu_req = 1'b0;

        chk({tag, "_ready"},   got, 1'b1);
        chk({tag, "_latency"}, n, exp_n);
        chk({tag, "_hit"},     cpu_hit, exp_hit);
        if (!we) chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
        chk({tag, "_mem_addr"},  mem_addr, ref_last_addr);
        chk({tag, "_wr_low"},    mem_write, 1'b0);
        chk({tag, "_wr_cycles"}, wr_cycles_total - wc0, exp_wb ? L : 0);
        chk({tag, "_wr_bursts"}, wr_rises_total - wr0, exp_wb ? 1 : 0);
        chk({tag, "_wr_stable"}, wr_unstable_total - wu0, 0);
        if (exp_wb) begin
            chk({tag, "_wb_addr"}, last_wr_addr, exp_wb_addr);
            chk({tag, "_wb_data"}, last_wr_data, exp_wb_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  rt;
        logic [9:0]  ra;
        int          gap;

        rst_n     = 1'b1;
        load_mem  = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 256; i++) init_img[i] = $urandom;
        init_img[0]  = 32'hC83FA926;
        init_img[64] = 32'hF0317449;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_img[i];
        model_clear();

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        load_mem = 1'b0;
        chk("rst_cpu_ready", cpu_ready, 1'b0);
        chk("rst_cpu_hit",   cpu_hit,   1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr",  mem_addr,  10'h0);
        chk("rst_mem_wt",    mem_wt,    128'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequence
        do_req(1'b0, 10'h000, 32'h0, "cold_load");
        chk("cold_load_data", cpu_rdata, 32'hC83FA926);
        do_req(1'b0, 10'h000, 32'h0, "repeat_load");
        do_req(1'b1, 10'h004, 32'hDEADBEEF, "store_hit");
        do_req(1'b0, 10'h100, 32'h0, "dirty_miss");
        chk("dirty_miss_data", cpu_rdata, 32'hF0317449);
        chk("wb_mem_word1", phys_mem[1], 32'hDEADBEEF);
        do_req(1'b0, 10'h000, 32'h0, "clean_victim");
        chk("clean_victim_data", cpu_rdata, 32'hC83FA926);
        do_req(1'b1, 10'h3FC, 32'h12345678, "store_miss");
        do_req(1'b0, 10'h3FC, 32'h0, "store_miss_rd");
        chk("store_miss_rd_data", cpu_rdata, 32'h12345678);
        do_req(1'b0, 10'h0F0, 32'h0, "evict_merged");

        // Randomised traffic over a few tags so lines conflict and re-hit
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0:       rt = 4'h0;
                1:       rt = 4'h5;
                default: rt = 4'hF;
            endcase
            ra = {rt, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_req(1'($urandom_range(0, 1)), ra, $urandom, $sformatf("rnd%0d", i));
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            if (gap != 0) #1;
        end

        // Reset during the second write-back cycle
        do_req(1'b1, 10'h000, 32'hA5A5A5A5, "pre_rst_store");
        for (int k = 0; k < 4; k++) ref_mem[k] = rc_words[0][k];
        model_clear();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'h100;
        repeat (3) @(posedge clk);
        #2;
        chk("wb2_mem_write", mem_write, 1'b1);
        chk("wb2_mem_addr",  mem_addr,  10'h000);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_write", mem_write, 1'b0);
        chk("abort_mem_addr",  mem_addr,  10'h0);
        chk("abort_mem_wt",    mem_wt,    128'h0);
        chk("abort_cpu_ready", cpu_ready, 1'b0);
        chk("abort_cpu_hit",   cpu_hit,   1'b0);
        chk("abort_cpu_rdata", cpu_rdata, 32'h0);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_mem_word0", phys_mem[0], 32'hA5A5A5A5);
        do_req(1'b0, 10'h000, 32'h0, "post_rst_load");
        chk("post_rst_data", cpu_rdata, 32'hA5A5A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
